// File: rtl/regfile_write_sequencer_if.sv
// regfile_write_sequencer_if: requester write bundle plus the register-file write port
interface regfile_write_sequencer_if #(
  parameter int N_REQ = 3,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] req_wide;
  logic [N_REQ-1:0] ack;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*2*DATA_W-1:0] req_data;
  logic busy;
  logic rf_write_enable;
  logic [ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;
  logic rf_dirc_byte;
  modport master (
    output req, req_wide, req_addr, req_data,
    input ack, busy, rf_write_enable, rf_write_addr, rf_write_data, rf_dirc_byte
  );
  modport slave (
    input req, req_wide, req_addr, req_data,
    output ack, busy, rf_write_enable, rf_write_addr, rf_write_data, rf_dirc_byte
  );
endinterface

// File: rtl/regfile_write_sequencer.sv
// regfile_write_sequencer: arbitrated register-file write port splitting wide writes into low/high halves; RF_SEQ_FIXED_PRIO_EN selects fixed priority
module regfile_write_sequencer #(
  parameter int N_REQ = 3,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int FIRST_WIDE_ADDR = 8,
  parameter int LAST_WIDE_ADDR = 9
) (
  input logic clk,
  input logic rst,
  regfile_write_sequencer_if.slave bus
);
  localparam int PTR_W = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam logic [ADDR_W-1:0] WIDE_LO = ADDR_W'(FIRST_WIDE_ADDR);
  localparam logic [ADDR_W-1:0] WIDE_HI = ADDR_W'(LAST_WIDE_ADDR);
  typedef enum logic {ARB, HI} state_t;
  state_t state_q, state_d;
  logic we_q, we_d;
  logic dirc_q, dirc_d;
  logic busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [PTR_W-1:0] win_q, win_d;
  logic [N_REQ-1:0] elig;
  logic [PTR_W-1:0] win, idx;
  logic found, w_wide;
  logic [ADDR_W-1:0] w_addr;
  logic [2*DATA_W-1:0] w_data;
`ifndef RF_SEQ_FIXED_PRIO_EN
  logic [PTR_W-1:0] rr_q, rr_d;
`endif
  always_comb begin
    elig = bus.req & ~ack_q;
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef RF_SEQ_FIXED_PRIO_EN
      idx = PTR_W'(k);
`else
      idx = PTR_W'((int'(rr_q) + k) % N_REQ);
`endif
      if (!found && elig[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
    w_addr = '0;
    w_data = '0;
    w_wide = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win == PTR_W'(k)) begin
        w_addr = bus.req_addr[k*ADDR_W +: ADDR_W];
        w_data = bus.req_data[k*2*DATA_W +: 2*DATA_W];
        w_wide = bus.req_wide[k] && w_addr >= WIDE_LO && w_addr <= WIDE_HI;
      end
    end
  end
  always_comb begin
    state_d = ARB;
    we_d = 1'b1;
    addr_d = '0;
    data_d = '0;
    dirc_d = 1'b0;
    ack_d = '0;
    busy_d = 1'b0;
    hi_d = hi_q;
    win_d = win_q;
`ifndef RF_SEQ_FIXED_PRIO_EN
    rr_d = rr_q;
`endif
    if (state_q == HI) begin
      we_d = 1'b0;
      addr_d = addr_q;
      data_d = hi_q;
      dirc_d = 1'b1;
      ack_d = N_REQ'(1) << win_q;
      busy_d = 1'b1;
    end else if (found) begin
      we_d = 1'b0;
      addr_d = w_addr;
      data_d = w_data[DATA_W-1:0];
      hi_d = w_data[2*DATA_W-1:DATA_W];
      win_d = win;
      busy_d = w_wide;
      state_d = w_wide ? HI : ARB;
      ack_d = w_wide ? '0 : N_REQ'(1) << win;
`ifndef RF_SEQ_FIXED_PRIO_EN
      rr_d = (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARB;
      we_q <= 1'b1;
      addr_q <= '0;
      data_q <= '0;
      dirc_q <= 1'b0;
      ack_q <= '0;
      busy_q <= 1'b0;
      hi_q <= '0;
      win_q <= '0;
`ifndef RF_SEQ_FIXED_PRIO_EN
      rr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      dirc_q <= dirc_d;
      ack_q <= ack_d;
      busy_q <= busy_d;
      hi_q <= hi_d;
      win_q <= win_d;
`ifndef RF_SEQ_FIXED_PRIO_EN
      rr_q <= rr_d;
`endif
    end
  end
  assign bus.ack = ack_q;
  assign bus.busy = busy_q;
  assign bus.rf_write_enable = we_q;
  assign bus.rf_write_addr = addr_q;
  assign bus.rf_write_data = data_q;
  assign bus.rf_dirc_byte = dirc_q;
endmodule

// File: tb/tb_regfile_write_sequencer.sv
// tb_regfile_write_sequencer: directed scenarios plus randomized traffic checked against a beat-queue model
module tb_regfile_write_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n = 0;
  int nf = 0;
  logic [3:0] ra [3];
  logic [31:0] rd [3];
  logic rq [3];
  logic rw [3];
  localparam logic [25:0] IDLE = {1'b1, 25'd0};
  regfile_write_sequencer_if #(.N_REQ(3), .ADDR_W(4), .DATA_W(16)) bus ();
  regfile_write_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [25:0] mk(logic we, logic [3:0] a, logic [15:0] d, logic dc, logic [2:0] ak, logic b);
    return {we, a, d, dc, ak, b};
  endfunction
  function automatic logic [25:0] obs();
    return {bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data, bus.rf_dirc_byte, bus.ack, bus.busy};
  endfunction
  task automatic push();
    logic [2:0] q, w;
    logic [11:0] a;
    logic [95:0] d;
    q = '0;
    w = '0;
    a = '0;
    d = '0;
    for (int i = 0; i < 3; i++) begin
      q |= 3'(rq[i]) << i;
      w |= 3'(rw[i]) << i;
      a |= 12'(ra[i]) << (4 * i);
      d |= 96'(rd[i]) << (32 * i);
    end
    bus.req = q;
    bus.req_wide = w;
    bus.req_addr = a;
    bus.req_data = d;
  endtask
  task automatic clear();
    for (int i = 0; i < 3; i++) begin
      rq[i] = 1'b0;
      rw[i] = 1'b0;
      ra[i] = '0;
      rd[i] = '0;
    end
    push();
  endtask
  task automatic set(int i, logic [3:0] a, logic [31:0] d, logic w);
    rq[i] = 1'b1;
    ra[i] = a;
    rd[i] = d;
    rw[i] = w;
    push();
  endtask
  task automatic drop(int i);
    rq[i] = 1'b0;
    push();
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    logic [25:0] e;
    rst = 1'b0;
    clear();
    cyc();
    cyc();
    e = IDLE; n++; if (obs() !== e) begin nf++; $display("FAIL reset_state got=%h exp=%h", obs(), e); end
    rst = 1'b1;
    cyc();
    e = IDLE; n++; if (obs() !== e) begin nf++; $display("FAIL reset_idle got=%h exp=%h", obs(), e); end
  endtask
  task automatic test_narrow();
    logic [25:0] e;
    set(0, 4'd3, 32'h0000_1234, 1'b0);
    cyc();
    e = mk(1'b0, 4'd3, 16'h1234, 1'b0, 3'b001, 1'b0); n++; if (obs() !== e) begin nf++; $display("FAIL narrow_c1 got=%h exp=%h", obs(), e); end
    drop(0);
    cyc();
    e = IDLE; n++; if (obs() !== e) begin nf++; $display("FAIL narrow_idle got=%h exp=%h", obs(), e); end
  endtask
  task automatic test_wide();
    logic [25:0] e;
    set(1, 4'd9, 32'hABCD_1234, 1'b1);
    cyc();
    e = mk(1'b0, 4'd9, 16'h1234, 1'b0, 3'b000, 1'b1); n++; if (obs() !== e) begin nf++; $display("FAIL wide_lo got=%h exp=%h", obs(), e); end
    rd[1] = 32'h5A5A_5A5A;
    push();
    cyc();
    e = mk(1'b0, 4'd9, 16'hABCD, 1'b1, 3'b010, 1'b1); n++; if (obs() !== e) begin nf++; $display("FAIL wide_hi got=%h exp=%h", obs(), e); end
    drop(1);
    cyc();
    e = IDLE; n++; if (obs() !== e) begin nf++; $display("FAIL wide_done got=%h exp=%h", obs(), e); end
  endtask
  task automatic test_back_to_back();
    logic [25:0] e;
    int seq [4];
`ifdef RF_SEQ_FIXED_PRIO_EN
    seq = '{0, 1, 0, 1};
`else
    seq = '{0, 1, 2, 0};
`endif
    rst = 1'b0;
    clear();
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) set(i, 4'(i + 1), 32'h1000 + 32'(i), 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      e = mk(1'b0, 4'(seq[k] + 1), 16'h1000 + 16'(seq[k]), 1'b0, 3'(1 << seq[k]), 1'b0); n++; if (obs() !== e) begin nf++; $display("FAIL b2b_%0d got=%h exp=%h", k, obs(), e); end
    end
    clear();
    cyc();
    e = IDLE; n++; if (obs() !== e) begin nf++; $display("FAIL b2b_idle got=%h exp=%h", obs(), e); end
  endtask
  task automatic test_reset_mid();
    logic [25:0] e;
    set(0, 4'd9, 32'hCAFE_0001, 1'b1);
    cyc();
    e = mk(1'b0, 4'd9, 16'h0001, 1'b0, 3'b000, 1'b1); n++; if (obs() !== e) begin nf++; $display("FAIL abort_lo got=%h exp=%h", obs(), e); end
    rst = 1'b0;
    cyc();
    e = IDLE; n++; if (obs() !== e) begin nf++; $display("FAIL abort_idle got=%h exp=%h", obs(), e); end
    rst = 1'b1;
    set(1, 4'd5, 32'h0000_0055, 1'b0);
    cyc();
    e = mk(1'b0, 4'd9, 16'h0001, 1'b0, 3'b000, 1'b1); n++; if (obs() !== e) begin nf++; $display("FAIL retry_lo got=%h exp=%h", obs(), e); end
    cyc();
    e = mk(1'b0, 4'd9, 16'hCAFE, 1'b1, 3'b001, 1'b1); n++; if (obs() !== e) begin nf++; $display("FAIL retry_hi got=%h exp=%h", obs(), e); end
    drop(0);
    cyc();
    e = mk(1'b0, 4'd5, 16'h0055, 1'b0, 3'b010, 1'b0); n++; if (obs() !== e) begin nf++; $display("FAIL retry_next got=%h exp=%h", obs(), e); end
    drop(1);
    cyc();
    e = IDLE; n++; if (obs() !== e) begin nf++; $display("FAIL retry_idle got=%h exp=%h", obs(), e); end
  endtask
  task automatic test_wide_narrow_addr();
    logic [25:0] e;
    set(2, 4'd2, 32'h5555_AAAA, 1'b1);
    cyc();
    e = mk(1'b0, 4'd2, 16'hAAAA, 1'b0, 3'b100, 1'b0); n++; if (obs() !== e) begin nf++; $display("FAIL wflag_narrow got=%h exp=%h", obs(), e); end
    drop(2);
    cyc();
    e = IDLE; n++; if (obs() !== e) begin nf++; $display("FAIL wflag_idle got=%h exp=%h", obs(), e); end
  endtask
  task automatic test_wide_then_pending();
    logic [25:0] e;
    set(0, 4'd8, 32'h8765_4321, 1'b1);
    set(2, 4'd4, 32'h0000_0444, 1'b0);
    cyc();
    e = mk(1'b0, 4'd8, 16'h4321, 1'b0, 3'b000, 1'b1); n++; if (obs() !== e) begin nf++; $display("FAIL pend_lo got=%h exp=%h", obs(), e); end
    cyc();
    e = mk(1'b0, 4'd8, 16'h8765, 1'b1, 3'b001, 1'b1); n++; if (obs() !== e) begin nf++; $display("FAIL pend_hi got=%h exp=%h", obs(), e); end
    drop(0);
    cyc();
    e = mk(1'b0, 4'd4, 16'h0444, 1'b0, 3'b100, 1'b0); n++; if (obs() !== e) begin nf++; $display("FAIL pend_next got=%h exp=%h", obs(), e); end
    drop(2);
    cyc();
    e = IDLE; n++; if (obs() !== e) begin nf++; $display("FAIL pend_idle got=%h exp=%h", obs(), e); end
  endtask
  task automatic test_random();
    logic [25:0] beats [$];
    logic [25:0] e;
    logic [2:0] last, el;
    logic [31:0] full;
    int rr, w;
    rst = 1'b0;
    clear();
    cyc();
    rst = 1'b1;
    rr = 0;
    last = '0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      if (!rst) begin
        beats.delete();
        rr = 0;
        e = IDLE;
      end else if (beats.size() > 0) begin
        e = beats.pop_front();
      end else begin
        el = {rq[2], rq[1], rq[0]} & ~last;
        w = -1;
        for (int k = 0; k < 3; k++) begin
`ifdef RF_SEQ_FIXED_PRIO_EN
          int j = k;
`else
          int j = (rr + k) % 3;
`endif
          if (w < 0 && el[j]) w = j;
        end
        if (w < 0) e = IDLE;
        else begin
          full = rd[w];
          if (rw[w] && ra[w] >= 4'd8 && ra[w] <= 4'd9) begin
            e = mk(1'b0, ra[w], full[15:0], 1'b0, 3'b000, 1'b1);
            beats.push_back(mk(1'b0, ra[w], full[31:16], 1'b1, 3'(1 << w), 1'b1));
          end else e = mk(1'b0, ra[w], full[15:0], 1'b0, 3'(1 << w), 1'b0);
          rr = (w + 1) % 3;
        end
      end
      last = e[3:1];
      #1;
      n++; if (obs() !== e) begin nf++; $display("FAIL rand_cycle_%0d got=%h exp=%h", c, obs(), e); end
      n++; if ($countones(bus.ack) > 1) begin nf++; $display("FAIL rand_onehot_%0d got=%b exp=at most one bit", c, bus.ack); end
      rst = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < 3; i++) begin
        if (last[i]) rq[i] = 1'b0;
        if (!rq[i] && $urandom_range(0, 2) == 0) begin
          rq[i] = 1'b1;
          ra[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(8 + $urandom_range(0, 1));
          rd[i] = $urandom;
          rw[i] = 1'($urandom_range(0, 1));
        end else if (rq[i] && $urandom_range(0, 7) == 0) rd[i] = $urandom;
      end
      push();
    end
    rst = 1'b1;
    clear();
  endtask
  initial begin
    test_reset();
    test_narrow();
    test_wide();
    test_back_to_back();
    test_reset_mid();
    test_wide_narrow_addr();
    test_wide_then_pending();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n, nf);
    $finish;
  end
endmodule
